// File: rtl/mc_alu_sequencer_if.sv
// Control/status bundle between the multi-cycle sequencer and the RV32I datapath.
// master = sequencer (drives strobes), slave = datapath/memory side.
interface mc_alu_sequencer_if;
    logic [31:0] instr;
    logic        alu_bcond;
    logic        halt_req;
    logic        mem_ready;
    logic [7:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        pc_write;
    logic        pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mdr_write;
    logic        ab_write;
    logic        alu_out_write;
    logic        reg_write;
    logic        mem_to_reg;

    modport master (
        input  instr, alu_bcond, halt_req, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_write, pc_source, i_or_d,
               mem_read, mem_write, ir_write, mdr_write, ab_write,
               alu_out_write, reg_write, mem_to_reg
    );

    modport slave (
        output instr, alu_bcond, halt_req, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_write, pc_source, i_or_d,
               mem_read, mem_write, ir_write, mdr_write, ab_write,
               alu_out_write, reg_write, mem_to_reg
    );
endinterface

// File: rtl/mc_alu_sequencer.sv
// Multi-cycle RV32I control FSM: IF/ID/EX/MEM/WB/PC4/HALT, drives ALU op and datapath strobes.
// Define MC_INSTR_COUNT_EN to build the retired-instruction counter; otherwise instr_count is 0.
//
// state  | meaning
// S_IF   | fetch, wait for mem_ready, load IR
// S_ID   | load A/B, ALUOut = PC+imm, ECALL halt check
// S_EX   | execute by opcode, resolve branches
// S_MEM  | load/store access, wait for mem_ready
// S_WB   | register file write, PC update
// S_PC4  | PC = PC+4 only (branch not taken, unknown op, ECALL no halt)
// S_HALT | absorbing halt until reset
module mc_alu_sequencer #(
    parameter int INSTR_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    mc_alu_sequencer_if.master     bus,
    output logic                   is_halted,
    output logic [INSTR_CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_PC4, S_HALT} state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [7:0] ALU_ADD = 8'h00;
    localparam logic [7:0] ALU_SUB = 8'h01;
    localparam logic [7:0] ALU_SLL = 8'h02;
    localparam logic [7:0] ALU_XOR = 8'h03;
    localparam logic [7:0] ALU_OR  = 8'h04;
    localparam logic [7:0] ALU_AND = 8'h05;
    localparam logic [7:0] ALU_SRL = 8'h06;
    localparam logic [7:0] ALU_SRA = 8'h07;
    localparam logic [7:0] ALU_BEQ = 8'h08;
    localparam logic [7:0] ALU_BNE = 8'h09;
    localparam logic [7:0] ALU_BLT = 8'h0A;
    localparam logic [7:0] ALU_BGE = 8'h0B;

    state_t     state, next_state;
    logic       retire;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;
    logic [7:0] arith_op;
    logic [7:0] branch_op;
    logic       unused_instr_bits;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign bit30  = bus.instr[30];
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    // SUB only exists for register-register; SRA applies to both R and I forms.
    always_comb begin
        arith_op = ALU_ADD;
        unique case (funct3)
            3'b000:  arith_op = (opcode == OP_R && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b100:  arith_op = ALU_XOR;
            3'b110:  arith_op = ALU_OR;
            3'b111:  arith_op = ALU_AND;
            3'b101:  arith_op = bit30 ? ALU_SRA : ALU_SRL;
            default: arith_op = ALU_ADD;
        endcase
    end

    always_comb begin
        branch_op = ALU_BEQ;
        unique case (funct3)
            3'b001:         branch_op = ALU_BNE;
            3'b100, 3'b110: branch_op = ALU_BLT;
            3'b101, 3'b111: branch_op = ALU_BGE;
            default:        branch_op = ALU_BEQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IF;
        else        state <= next_state;
    end

    always_comb begin
        next_state        = state;
        retire            = 1'b0;
        is_halted         = 1'b0;
        bus.alu_op        = ALU_ADD;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.pc_write      = 1'b0;
        bus.pc_source     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mdr_write     = 1'b0;
        bus.ab_write      = 1'b0;
        bus.alu_out_write = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;

        // Reset gates the outputs combinationally so strobes drop the moment reset asserts.
        if (reset) begin
            unique case (state)
                S_IF: begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        next_state   = S_ID;
                    end
                end
                S_ID: begin
                    bus.ab_write      = 1'b1;
                    bus.alu_src_b     = 2'd2;
                    bus.alu_out_write = 1'b1;
                    if (opcode == OP_ECALL) next_state = bus.halt_req ? S_HALT : S_PC4;
                    else                    next_state = S_EX;
                end
                S_EX: begin
                    unique case (opcode)
                        OP_R, OP_I: begin
                            bus.alu_src_a     = 1'b1;
                            bus.alu_src_b     = (opcode == OP_I) ? 2'd2 : 2'd0;
                            bus.alu_op        = arith_op;
                            bus.alu_out_write = 1'b1;
                            next_state        = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            bus.alu_src_a     = 1'b1;
                            bus.alu_src_b     = 2'd2;
                            bus.alu_out_write = 1'b1;
                            next_state        = S_MEM;
                        end
                        OP_BRANCH: begin
                            bus.alu_src_a = 1'b1;
                            bus.alu_op    = branch_op;
                            if (bus.alu_bcond) begin
                                bus.pc_write  = 1'b1;
                                bus.pc_source = 1'b1;
                                retire        = 1'b1;
                                next_state    = S_IF;
                            end else begin
                                next_state = S_PC4;
                            end
                        end
                        OP_JAL, OP_JALR: begin
                            // Link value PC+4 is formed from the old PC while the jump target loads.
                            bus.alu_src_b     = 2'd1;
                            bus.alu_out_write = 1'b1;
                            bus.pc_write      = (opcode == OP_JAL);
                            bus.pc_source     = (opcode == OP_JAL);
                            next_state        = S_WB;
                        end
                        default: next_state = S_PC4;
                    endcase
                end
                S_MEM: begin
                    bus.i_or_d = 1'b1;
                    if (opcode == OP_STORE) begin
                        bus.mem_write = 1'b1;
                        if (bus.mem_ready) begin
                            bus.alu_src_b = 2'd1;
                            bus.pc_write  = 1'b1;
                            retire        = 1'b1;
                            next_state    = S_IF;
                        end
                    end else begin
                        bus.mem_read = 1'b1;
                        if (bus.mem_ready) begin
                            bus.mdr_write = 1'b1;
                            next_state    = S_WB;
                        end
                    end
                end
                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = (opcode == OP_LOAD);
                    retire         = 1'b1;
                    next_state     = S_IF;
                    if (opcode == OP_JALR) begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = 2'd2;
                        bus.pc_write  = 1'b1;
                    end else if (opcode != OP_JAL) begin
                        bus.alu_src_b = 2'd1;
                        bus.pc_write  = 1'b1;
                    end
                end
                S_PC4: begin
                    bus.alu_src_b = 2'd1;
                    bus.pc_write  = 1'b1;
                    retire        = 1'b1;
                    next_state    = S_IF;
                end
                S_HALT: begin
                    is_halted  = 1'b1;
                    next_state = S_HALT;
                end
                default: next_state = S_IF;
            endcase
        end
    end

`ifdef MC_INSTR_COUNT_EN
    logic [INSTR_CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      count_q <= '0;
        else if (retire) count_q <= count_q + INSTR_CNT_W'(1);
    end

    assign instr_count = count_q;
`else
    logic unused_retire;

    assign unused_retire = retire;
    assign instr_count   = '0;
`endif
endmodule

// File: tb/tb_mc_alu_sequencer.sv
// Directed self-checking bench for mc_alu_sequencer; expectations are hand-derived per instruction phase.
module tb_mc_alu_sequencer;
    logic        clk;
    logic        reset;
    logic        is_halted;
    logic [31:0] instr_count;
    int          n_cmp = 0;
    int          n_bad = 0;

    mc_alu_sequencer_if bif ();

    mc_alu_sequencer #(.INSTR_CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bif.master),
        .is_halted   (is_halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] I_ADD   = 32'h002080B3;
    localparam logic [31:0] I_SUB   = 32'h40208033;
    localparam logic [31:0] I_ADDI  = 32'h40010093;
    localparam logic [31:0] I_SRAI  = 32'h40315093;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_LW    = 32'h00012083;
    localparam logic [31:0] I_SW    = 32'h00112023;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_ECALL = 32'h00000073;

    logic [13:0] strobes;
    logic        in_if;
    assign strobes = {bif.pc_write, bif.pc_source, bif.i_or_d, bif.mem_read, bif.mem_write,
                      bif.ir_write, bif.mdr_write, bif.ab_write, bif.alu_out_write,
                      bif.reg_write, bif.mem_to_reg, bif.alu_src_a, bif.alu_src_b};
    assign in_if = (bif.mem_read === 1'b1) && (bif.i_or_d === 1'b0);

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Steps from the current IF cycle until the FSM is back in IF; bounded.
    task automatic run_instr(input logic [31:0] ins, input logic bc, output int cyc);
        bif.instr     = ins;
        bif.alu_bcond = bc;
        bif.mem_ready = 1'b1;
        cyc = 1;
        next_cycle();
        while (!in_if && cyc < 40) begin
            cyc++;
            next_cycle();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bif.instr = I_ADD; bif.alu_bcond = 1'b0; bif.halt_req = 1'b0; bif.mem_ready = 1'b1;
        #12;
        n_cmp++; if (strobes !== 14'h0) begin n_bad++; $display("FAIL reset_strobes got=%h exp=0", strobes); end
        n_cmp++; if (bif.alu_op !== 8'h00) begin n_bad++; $display("FAIL reset_alu_op got=%h exp=00", bif.alu_op); end
        n_cmp++; if (is_halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got=%b exp=0", is_halted); end
        n_cmp++; if (instr_count !== 32'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
        @(negedge clk); reset = 1'b1; #1;
        n_cmp++; if (!in_if || bif.ir_write !== 1'b1) begin n_bad++; $display("FAIL release_if mem_read=%b ir_write=%b exp=1/1", bif.mem_read, bif.ir_write); end
    endtask

    task automatic test_reset_mid_ex();
        bif.instr = I_ADD; bif.mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        n_cmp++; if (bif.alu_out_write !== 1'b1 || bif.alu_src_a !== 1'b1) begin n_bad++; $display("FAIL midex_ex got aow=%b src_a=%b exp=1/1", bif.alu_out_write, bif.alu_src_a); end
        #2 reset = 1'b0; #1;
        n_cmp++; if (strobes !== 14'h0) begin n_bad++; $display("FAIL midex_strobes got=%h exp=0", strobes); end
        @(negedge clk); reset = 1'b1; #1;
        n_cmp++; if (!in_if || bif.alu_out_write !== 1'b0) begin n_bad++; $display("FAIL midex_resume mem_read=%b aow=%b exp=1/0", bif.mem_read, bif.alu_out_write); end
    endtask

    task automatic test_rtype();
        bif.instr = I_SUB; bif.mem_ready = 1'b1; #1;
        n_cmp++; if (bif.ir_write !== 1'b1) begin n_bad++; $display("FAIL sub_if ir_write got=%b exp=1", bif.ir_write); end
        next_cycle();
        n_cmp++; if ({bif.ab_write, bif.alu_out_write, bif.alu_src_a, bif.alu_src_b, bif.alu_op} !== {3'b110, 2'd2, 8'h00})
            begin n_bad++; $display("FAIL sub_id ab/aow/a=%b%b%b b=%0d op=%h exp=110 2 00", bif.ab_write, bif.alu_out_write, bif.alu_src_a, bif.alu_src_b, bif.alu_op); end
        next_cycle();
        n_cmp++; if ({bif.alu_op, bif.alu_src_a, bif.alu_src_b, bif.alu_out_write} !== {8'h01, 1'b1, 2'd0, 1'b1})
            begin n_bad++; $display("FAIL sub_ex op=%h a=%b b=%0d aow=%b exp=01 1 0 1", bif.alu_op, bif.alu_src_a, bif.alu_src_b, bif.alu_out_write); end
        next_cycle();
        n_cmp++; if ({bif.reg_write, bif.pc_write, bif.pc_source, bif.mem_to_reg} !== 4'b1100)
            begin n_bad++; $display("FAIL sub_wb rw/pw/ps/m2r=%b%b%b%b exp=1100", bif.reg_write, bif.pc_write, bif.pc_source, bif.mem_to_reg); end
        next_cycle();
        n_cmp++; if (!in_if) begin n_bad++; $display("FAIL sub_cycles not back in IF after 4 cycles exp=IF"); end
    endtask

    task automatic test_itype();
        int cyc;
        bif.instr = I_ADDI; bif.mem_ready = 1'b1;
        next_cycle(); next_cycle();
        n_cmp++; if ({bif.alu_op, bif.alu_src_a, bif.alu_src_b} !== {8'h00, 1'b1, 2'd2})
            begin n_bad++; $display("FAIL addi_ex op=%h a=%b b=%0d exp=00 1 2", bif.alu_op, bif.alu_src_a, bif.alu_src_b); end
        next_cycle(); next_cycle();
        bif.instr = I_SRAI;
        next_cycle(); next_cycle();
        n_cmp++; if (bif.alu_op !== 8'h07) begin n_bad++; $display("FAIL srai_ex op got=%h exp=07", bif.alu_op); end
        next_cycle(); next_cycle();
        run_instr(I_JAL, 1'b0, cyc);
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL jal_cycles got=%0d exp=4", cyc); end
    endtask

    task automatic test_branch();
        int cyc;
        bif.instr = I_BEQ; bif.alu_bcond = 1'b1; bif.mem_ready = 1'b1;
        next_cycle(); next_cycle();
        n_cmp++; if ({bif.alu_op, bif.pc_write, bif.pc_source} !== {8'h08, 2'b11})
            begin n_bad++; $display("FAIL beq_taken op=%h pw=%b ps=%b exp=08 1 1", bif.alu_op, bif.pc_write, bif.pc_source); end
        next_cycle();
        n_cmp++; if (!in_if) begin n_bad++; $display("FAIL beq_taken_cycles not in IF after 3 exp=IF"); end
        bif.alu_bcond = 1'b0;
        next_cycle(); next_cycle();
        n_cmp++; if (bif.pc_write !== 1'b0) begin n_bad++; $display("FAIL beq_nt_ex pw got=%b exp=0", bif.pc_write); end
        next_cycle();
        n_cmp++; if ({bif.pc_write, bif.pc_source, bif.alu_src_b, bif.reg_write} !== {2'b10, 2'd1, 1'b0})
            begin n_bad++; $display("FAIL beq_pc4 pw=%b ps=%b b=%0d rw=%b exp=1 0 1 0", bif.pc_write, bif.pc_source, bif.alu_src_b, bif.reg_write); end
        next_cycle();
        n_cmp++; if (!in_if) begin n_bad++; $display("FAIL beq_nt_cycles not in IF after 4 exp=IF"); end
        run_instr(I_SW, 1'b0, cyc);
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL sw_cycles got=%0d exp=4", cyc); end
    endtask

    task automatic test_load_wait();
        logic mr [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int ir_cnt = 0;
        int mdr_cnt = 0;
        bif.instr = I_LW;
        for (int i = 0; i < 10; i++) begin
            bif.mem_ready = mr[i];
            #1;
            ir_cnt  += int'(bif.ir_write);
            mdr_cnt += int'(bif.mdr_write);
            if (i == 6) begin
                n_cmp++; if ({bif.i_or_d, bif.mem_read, bif.mdr_write} !== 3'b110)
                    begin n_bad++; $display("FAIL lw_mem_wait iod/rd/mdr=%b%b%b exp=110", bif.i_or_d, bif.mem_read, bif.mdr_write); end
            end
            if (i == 9) begin
                n_cmp++; if ({bif.reg_write, bif.mem_to_reg, bif.pc_write} !== 3'b111)
                    begin n_bad++; $display("FAIL lw_wb rw/m2r/pw=%b%b%b exp=111", bif.reg_write, bif.mem_to_reg, bif.pc_write); end
            end
            next_cycle();
        end
        bif.mem_ready = 1'b1; #1;
        n_cmp++; if (!in_if) begin n_bad++; $display("FAIL lw_cycles not in IF after 10 exp=IF"); end
        n_cmp++; if (ir_cnt !== 1 || mdr_cnt !== 1) begin n_bad++; $display("FAIL lw_pulses ir=%0d mdr=%0d exp=1/1", ir_cnt, mdr_cnt); end
    endtask

    task automatic test_jalr();
        bif.instr = I_JALR; bif.mem_ready = 1'b1;
        next_cycle(); next_cycle();
        n_cmp++; if ({bif.alu_out_write, bif.alu_src_a, bif.alu_src_b, bif.pc_write} !== {2'b10, 2'd1, 1'b0})
            begin n_bad++; $display("FAIL jalr_ex aow=%b a=%b b=%0d pw=%b exp=1 0 1 0", bif.alu_out_write, bif.alu_src_a, bif.alu_src_b, bif.pc_write); end
        next_cycle();
        n_cmp++; if ({bif.reg_write, bif.alu_src_a, bif.alu_src_b, bif.pc_write, bif.pc_source} !== {2'b11, 2'd2, 2'b10})
            begin n_bad++; $display("FAIL jalr_wb rw=%b a=%b b=%0d pw=%b ps=%b exp=1 1 2 1 0", bif.reg_write, bif.alu_src_a, bif.alu_src_b, bif.pc_write, bif.pc_source); end
        next_cycle();
    endtask

    task automatic test_halt();
        int cyc;
        logic [31:0] exp_cnt;
        reset = 1'b0; #1;
        @(negedge clk); reset = 1'b1;
        bif.halt_req = 1'b0;
        run_instr(I_ADDI, 1'b0, cyc);
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL halt_pre_addi got=%0d exp=4", cyc); end
        run_instr(I_SW, 1'b0, cyc);
        run_instr(I_ECALL, 1'b0, cyc);
        n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL ecall_nohalt_cycles got=%0d exp=3", cyc); end
        bif.instr = I_ECALL; bif.halt_req = 1'b1;
        next_cycle(); next_cycle();
        n_cmp++; if (is_halted !== 1'b1 || strobes !== 14'h0)
            begin n_bad++; $display("FAIL halt_enter halted=%b strobes=%h exp=1 0", is_halted, strobes); end
        bif.halt_req = 1'b0;
        repeat (3) next_cycle();
        n_cmp++; if (is_halted !== 1'b1 || strobes !== 14'h0)
            begin n_bad++; $display("FAIL halt_hold halted=%b strobes=%h exp=1 0", is_halted, strobes); end
`ifdef MC_INSTR_COUNT_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        n_cmp++; if (instr_count !== exp_cnt) begin n_bad++; $display("FAIL halt_count got=%0d exp=%0d", instr_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_ex();
        test_rtype();
        test_itype();
        test_branch();
        test_load_wait();
        test_jalr();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
